// File: rtl/design_48_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | design_48_adder_if : start/operand/result bundle for the registered adder  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface design_48_adder_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         valid;

  modport master (output start, output a, output b, input y, input valid);
  modport slave  (input start, input a, input b, output y, output valid);
endinterface
`default_nettype wire

// File: rtl/design_48_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | design_48_adder : latency-1 registered W-bit adder with start/valid strobe |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module design_48_adder #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  design_48_adder_if.slave  bus
);

  logic [W-1:0] y_q;
  logic [W-1:0] y_d;
  logic         valid_q;
  logic         valid_d;

  // Carry-out is dropped on purpose: the result wraps modulo 2^W.
  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    if (bus.start) begin
      y_d     = bus.a + bus.b;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_design_48_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_design_48_adder : directed vector bench for the registered adder        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_design_48_adder;

  localparam int W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  design_48_adder_if #(.W(W)) bus ();

  design_48_adder #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         exp_valid;
    logic [W-1:0] exp_y;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic exp_v, input logic [W-1:0] exp_y);
    check({name, ".valid"}, {{(W-1){1'b0}}, bus.valid}, {{(W-1){1'b0}}, exp_v});
    check({name, ".y"}, bus.y, exp_y);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] held;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0]  = '{1'b1, 16'h0123, 16'h0210, 1'b1, 16'h0333};
    vecs[1]  = '{1'b0, 16'h1111, 16'h2222, 1'b0, 16'h0333};
    vecs[2]  = '{1'b1, 16'hFFFF, 16'h0002, 1'b1, 16'h0001};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001};
    vecs[4]  = '{1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0000};
    vecs[5]  = '{1'b0, 16'hABCD, 16'h1234, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 16'd1,    16'd2,    1'b1, 16'd3};
    vecs[7]  = '{1'b1, 16'd10,   16'd20,   1'b1, 16'd30};
    vecs[8]  = '{1'b1, 16'd100,  16'd200,  1'b1, 16'd300};
    vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'd300};
    vecs[10] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE};
    vecs[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFE};

    // Reset held while inputs toggle
    #1;
    check_out("reset_async", 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      bus.start = ~bus.start;
      bus.a     = 16'h1000 + 16'(i);
      bus.b     = 16'h0F00;
      step();
      check_out("reset_hold", 1'b0, 16'h0000);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_out("post_reset_idle", 1'b0, 16'h0000);
    end

    // Directed table
    for (int i = 0; i < 12; i++) begin
      bus.start = vecs[i].start;
      bus.a     = vecs[i].a;
      bus.b     = vecs[i].b;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_y);
    end

    // Random transactions with two idle cycles between them
    for (int t = 0; t < 10; t++) begin
      ra        = 16'($urandom_range(0, 1023));
      rb        = 16'($urandom_range(0, 1023));
      held      = ra + rb;
      bus.start = 1'b1;
      bus.a     = ra;
      bus.b     = rb;
      step();
      check_out($sformatf("rand%0d", t), 1'b1, held);
      bus.start = 1'b0;
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
      for (int k = 0; k < 2; k++) begin
        step();
        check_out($sformatf("rand%0d_idle", t), 1'b0, held);
      end
    end

    // Reset asserted between the start edge and the valid-sampling edge
    bus.start = 1'b1;
    bus.a     = 16'd5;
    bus.b     = 16'd7;
    step();
    check_out("mid_start", 1'b1, 16'd12);
    bus.start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_out("mid_rst_async", 1'b0, 16'h0000);
    step();
    check_out("mid_rst_hold", 1'b0, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_out("mid_rst_release", 1'b0, 16'h0000);
    end

    // First edge after release is an ordinary edge
    rst = 1'b1;
    step();
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.a     = 16'h0040;
    bus.b     = 16'h0002;
    step();
    check_out("first_edge_start", 1'b1, 16'h0042);
    bus.start = 1'b0;
    step();
    check_out("first_edge_after", 1'b0, 16'h0042);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
